// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   fetch_state_e    - fetch FSM state encoding (IDLE, REQ, FULL)
//   redirect_sel_e   - control-flow target selector codes
//   DEFAULT_RESET_PC - default first fetch address after reset
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_FULL = 2'b10
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_BRANCH = 2'b00,
    SEL_JUMP   = 2'b01,
    SEL_REG    = 2'b10,
    SEL_RSVD   = 2'b11
  } redirect_sel_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational control-flow target computation.
// Ports:
//   sel          in  2  target selector (branch / jump / register / reserved)
//   inst_low     in  26 inst[25:0] of the held instruction
//   pc_plus4     in  32 address of the held instruction plus 4
//   reg_word     in  30 redirect_reg[31:2]; byte offset is discarded
//   target       out 32 word-aligned redirect target
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [25:0] inst_low,
  input  logic [31:0] pc_plus4,
  input  logic [29:0] reg_word,
  output logic [31:0] target
);

  logic [31:0] branch_off;

  // Sign-extend the 16-bit offset and scale it to bytes in one step.
  assign branch_off = {{14{inst_low[15]}}, inst_low[15:0], 2'b00};

  always_comb begin
    // Reserved selector code falls back to the branch target.
    target = pc_plus4 + branch_off;
    case (redirect_sel_e'(sel))
      SEL_JUMP: target = {pc_plus4[31:28], inst_low, 2'b00};
      SEL_REG:  target = {reg_word, 2'b00};
      default:  ;
    endcase
  end

endmodule : next_pc_calc

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding-request instruction fetch unit.
// Fetches one word per request, holds it for decode, and reloads the PC
// from a redirect target when the held instruction is accepted.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   imem_req/imem_addr  read request and word-aligned address (out)
//   imem_ack/imem_rdata read completion and data (in)
//   inst_valid          held instruction is valid (out)
//   inst_ready          decode accepts the held instruction (in)
//   inst/imm16/pc_plus4 held instruction, its low half, its address + 4 (out)
//   redirect_valid/sel/reg  control-flow change for the accepted instruction (in)
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [15:0] imm16,
  output logic [31:0] pc_plus4,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_sel,
  input  logic [31:0] redirect_reg
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic [31:0]  redirect_target;

  next_pc_calc u_next_pc_calc (
    .sel      (redirect_sel),
    .inst_low (inst_q[25:0]),
    .pc_plus4 (pc_plus4_q),
    .reg_word (redirect_reg[31:2]),
    .target   (redirect_target)
  );

  always_comb begin
    // NOTE: every next-state value defaults to "hold" first, so paths that
    // do not assign it cannot infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    pc_plus4_d = pc_plus4_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          inst_d     = imem_rdata;
          pc_plus4_d = pc_q + 32'd4;   // wraps naturally at 2^32
          pc_d       = pc_q + 32'd4;
          state_d    = ST_FULL;
        end
      end
      ST_FULL: begin
        // imem_ack is not looked at here: stray acks leave everything alone.
        if (inst_ready) begin
          if (redirect_valid) pc_d = redirect_target;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the hold registers are reset too, because inst/pc_plus4 are
  // visible outputs that must read zero while in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      pc_plus4_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the
      // same pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign imem_req   = (state_q == ST_REQ);
  assign inst_valid = (state_q == ST_FULL);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign imm16      = inst_q[15:0];
  assign pc_plus4   = pc_plus4_q;

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch. Inputs change on the falling edge and
// outputs are compared on the falling edge, half a cycle after the DUT's
// rising edge.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [15:0] imm16;
  logic [31:0] pc_plus4;
  logic        redirect_valid;
  logic [1:0]  redirect_sel;
  logic [31:0] redirect_reg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .imm16          (imm16),
    .pc_plus4       (pc_plus4),
    .redirect_valid (redirect_valid),
    .redirect_sel   (redirect_sel),
    .redirect_reg   (redirect_reg)
  );

  // Wait (bounded) for a request, check its address stays put for `delay`
  // cycles, then ack with rdata and check the held result one cycle later.
  task automatic fetch(input string name, input logic [31:0] exp_addr,
                       input logic [31:0] rdata, input int delay);
    int waited = 0;
    @(negedge clk);
    while (!imem_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL %s req_timeout: imem_req=%b required 1", name, imem_req);
    end
    n_cmp++;
    if (imem_addr !== exp_addr) begin
      n_err++;
      $display("FAIL %s addr: got %h required %h", name, imem_addr, exp_addr);
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr || inst_valid !== 1'b0) begin
        n_err++;
        $display("FAIL %s wait%0d: req=%b addr=%h valid=%b required 1/%h/0",
                 name, i, imem_req, imem_addr, inst_valid, exp_addr);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    n_cmp++;
    if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst !== rdata ||
        imm16 !== rdata[15:0] || pc_plus4 !== exp_addr + 32'd4) begin
      n_err++;
      $display("FAIL %s hold: valid=%b req=%b inst=%h imm16=%h pc4=%h required 1/0/%h/%h/%h",
               name, inst_valid, imem_req, inst, imm16, pc_plus4,
               rdata, rdata[15:0], exp_addr + 32'd4);
    end
  endtask

  // Accept the held instruction with an optional redirect and check the
  // address of the following request.
  task automatic accept(input string name, input logic redir, input logic [1:0] sel,
                        input logic [31:0] rreg, input logic [31:0] exp_next);
    inst_ready     = 1'b1;
    redirect_valid = redir;
    redirect_sel   = sel;
    redirect_reg   = rreg;
    @(negedge clk);
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_next) begin
      n_err++;
      $display("FAIL %s next: valid=%b req=%b addr=%h required 0/1/%h",
               name, inst_valid, imem_req, imem_addr, exp_next);
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0 ||
        inst !== 32'h0 || imm16 !== 16'h0 || pc_plus4 !== 32'h0) begin
      n_err++;
      $display("FAIL reset_values: req=%b valid=%b addr=%h inst=%h imm=%h pc4=%h required all 0",
               imem_req, inst_valid, imem_addr, inst, imm16, pc_plus4);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // One rising edge after release: still IDLE for that first cycle done,
    // request now visible (second cycle after release).
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL first_req_cycle: req=%b addr=%h required 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_first_fetch();
    fetch("first", 32'h0000_0000, 32'h3C01_1234, 0);
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = inst;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        imem_ack   = 1'b1;   // stray ack while FULL
        imem_rdata = 32'h1111_2222;
      end
      @(negedge clk);
      imem_ack = 1'b0;
      n_cmp++;
      if (inst !== 32'h3C01_1234 || imm16 !== 16'h1234 || pc_plus4 !== 32'h4 ||
          imem_req !== 1'b0 || inst_valid !== 1'b1 || inst !== held) begin
        n_err++;
        $display("FAIL stall%0d: inst=%h pc4=%h req=%b valid=%b required 3c011234/4/0/1",
                 i, inst, pc_plus4, imem_req, inst_valid);
      end
    end
    accept("stall", 1'b0, 2'b00, 32'h0, 32'h0000_0004);
  endtask

  task automatic test_delayed_reg();
    fetch("delayed", 32'h0000_0004, 32'h0040_F809, 4);
    accept("reg_redirect", 1'b1, 2'b10, 32'h0000_2003, 32'h0000_2000);
  endtask

  task automatic test_branch();
    fetch("pre_branch", 32'h0000_2000, 32'h0000_0000, 1);
    accept("to_fc", 1'b1, 2'b10, 32'h0000_00FC, 32'h0000_00FC);
    fetch("branch_inst", 32'h0000_00FC, 32'h1000_FFFF, 0);
    accept("branch", 1'b1, 2'b00, 32'h0, 32'h0000_00FC);
  endtask

  task automatic test_jump();
    fetch("pre_jump", 32'h0000_00FC, 32'h0000_0000, 0);
    accept("to_a00c", 1'b1, 2'b10, 32'hA000_000C, 32'hA000_000C);
    fetch("jump_inst", 32'hA000_000C, 32'h0800_0040, 2);
    accept("jump", 1'b1, 2'b01, 32'h0, 32'hA000_0100);
  endtask

  task automatic test_reserved_sel();
    fetch("rsvd_inst", 32'hA000_0100, 32'h1000_0002, 0);
    accept("rsvd_as_branch", 1'b1, 2'b11, 32'h0000_5000, 32'hA000_010C);
  endtask

  task automatic test_redirect_ignored();
    fetch("ign_inst", 32'hA000_010C, 32'h0000_0000, 0);
    redirect_valid = 1'b1;
    redirect_sel   = 2'b10;
    redirect_reg   = 32'h0000_5000;
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b1 || imem_addr !== 32'hA000_0110) begin
      n_err++;
      $display("FAIL ignored_hold: valid=%b addr=%h required 1/a0000110", inst_valid, imem_addr);
    end
    accept("ignored_seq", 1'b0, 2'b10, 32'h0000_5000, 32'hA000_0110);
  endtask

  task automatic test_wrap();
    fetch("pre_wrap", 32'hA000_0110, 32'h0000_0000, 0);
    accept("to_top", 1'b1, 2'b10, 32'hFFFF_FFFE, 32'hFFFF_FFFC);
    fetch("wrap", 32'hFFFF_FFFC, 32'h2400_0001, 0);
    accept("wrap_next", 1'b0, 2'b00, 32'h0, 32'h0000_0000);
  endtask

  task automatic test_reset_mid_req();
    fetch("pre_rst", 32'h0000_0000, 32'h0000_0000, 0);
    accept("to_req4", 1'b0, 2'b00, 32'h0, 32'h0000_0004);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0 ||
        inst !== 32'h0 || imm16 !== 16'h0 || pc_plus4 !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: req=%b addr=%h valid=%b inst=%h imm=%h pc4=%h required all 0",
               imem_req, imem_addr, inst_valid, inst, imm16, pc_plus4);
    end
    imem_ack   = 1'b1;   // late ack straddling reset release
    imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0 || inst !== 32'h0) begin
      n_err++;
      $display("FAIL late_ack: req=%b addr=%h valid=%b inst=%h required 1/0/0/0",
               imem_req, imem_addr, inst_valid, inst);
    end
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL late_ack_hold: req=%b valid=%b required 1/0", imem_req, inst_valid);
    end
    fetch("post_rst", 32'h0000_0000, 32'h3C02_ABCD, 0);
  endtask

  initial begin
    reset_n        = 1'b0;
    imem_ack       = 1'b0;
    imem_rdata     = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_sel   = 2'b00;
    redirect_reg   = 32'h0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_delayed_reg();
    test_branch();
    test_jump();
    test_reserved_sel();
    test_redirect_ignored();
    test_wrap();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_inst_fetch

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first instruction address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port imem_req  output  1  instruction memory read request.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address.
REQ-006 SHALL have port imem_ack  input  1  memory read complete; imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port inst_valid  output  1  inst, imm16 and pc_plus4 hold a valid instruction.
REQ-009 SHALL have port inst_ready  input  1  decode accepts the held instruction.
REQ-010 SHALL have port inst  output  32  held instruction word.
REQ-011 SHALL have port imm16  output  16  inst[15:0], fed to the upper-immediate and sign-extend units.
REQ-012 SHALL have port pc_plus4  output  32  address of held instruction plus 4.
REQ-013 SHALL have port redirect_valid  input  1  the instruction being accepted changes control flow.
REQ-014 SHALL have port redirect_sel  input  2  00 branch, 01 jump, 10 register, 11 reserved (treated as 00).
REQ-015 SHALL have port redirect_reg  input  32  register target for jr/jalr.

Function
REQ-016 SHALL implement states IDLE, REQ, FULL.
REQ-017 IDLE: imem_req=0, inst_valid=0; SHALL go to REQ unconditionally on the next edge.
REQ-018 REQ: imem_req=1, imem_addr=pc, both held stable until imem_ack; inst_valid=0.
REQ-019 REQ with imem_ack=1: SHALL latch imem_rdata into inst, set pc_plus4=pc+4, set pc=pc+4, go to FULL; imem_req deasserts the cycle after ack.
REQ-020 FULL: inst_valid=1, imem_req=0; inst/imm16/pc_plus4 SHALL stay stable while inst_ready=0.
REQ-021 FULL with inst_ready=1: SHALL go to REQ; inst_valid deasserts the next cycle; one outstanding request at a time, one instruction per fetch.
REQ-022 Redirect SHALL be sampled only when inst_valid=1 and inst_ready=1; ignored otherwise.
REQ-023 Branch target SHALL be pc_plus4 + (sign-extended inst[15:0] shifted left 2), modulo 2^32.
REQ-024 Jump target SHALL be {pc_plus4[31:28], inst[25:0], 2'b00}.
REQ-025 Register target SHALL be {redirect_reg[31:2], 2'b00}; low two bits discarded.
REQ-026 On an accepted redirect, pc SHALL load the target, and the next REQ SHALL present it on imem_addr.
REQ-027 pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-028 imem_ack outside REQ SHALL be ignored; no state or output change.
REQ-029 Fetch latency SHALL be one cycle from imem_ack to inst_valid=1.

Reset
REQ-030 Asserting reset_n=0 SHALL immediately force state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, imm16=0, pc_plus4=0.
REQ-031 Reset mid-request SHALL abandon the request; a late imem_ack after reset release SHALL be ignored per REQ-028.
REQ-032 The first request SHALL be issued in the second cycle after reset_n rises (IDLE then REQ).

Structure
REQ-033 A shared package fetch_pkg SHALL hold the state encoding, the redirect_sel codes and the default reset PC constant.
REQ-034 Target computation (REQ-023 to REQ-025) SHALL be a combinational sub-module next_pc_calc; the FSM, pc and hold registers stay in inst_fetch.

Verification
REQ-035 Reset release, imem_ack one cycle after imem_req, imem_rdata=32'h3C01_1234 -> imem_addr=0, then inst_valid=1, imm16=16'h1234, pc_plus4=4.
REQ-036 inst_ready=0 for 5 cycles in FULL -> inst stable, imem_req=0; inst_ready=1 -> next imem_addr=4.
REQ-037 Held inst with imm16=16'hFFFF, pc_plus4=32'h100, branch redirect -> next imem_addr=32'h0000_00FC.
REQ-038 Jump with pc_plus4=32'hA000_0010, inst[25:0]=26'h000_0040 -> next imem_addr=32'hA000_0100; register redirect with 32'h0000_2003 -> 32'h0000_2000.
REQ-039 imem_ack delayed 4 cycles -> imem_addr stable throughout; stray ack in FULL -> no change.
REQ-040 reset_n low during REQ -> outputs at reset values immediately, pc=RESET_PC; late ack after release ignored.
